// File: rtl/global_mem_model.sv
// -----------------------------------------------------------------------------
// global_mem_model
//
// Cycle-level global memory responder used as the far end of the GPU's
// mem2fetch_*, mem2read_* and mem2write_* ports in system simulation. It holds
// a separate instruction array (fetch only) and data array (data channels
// only). Every channel runs its own IDLE/BUSY/RESP FSM with a 4-bit latency
// counter, so channels never stall one another.
//
// Handshakes: a transfer happens on a rising edge where valid=1 and ready=1.
// Ready and all response outputs depend only on registered state, never on
// the current inputs.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   mem2fetch_req_*         fetch request (val/rdy/addr)
//   mem2fetch_resp_*        fetched instruction (val/rdy/inst)
//   mem2read_req_*          per-channel read request (addr_val/rdy/addr)
//   mem2read_resp_*         per-channel read data (data_val/rdy/data)
//   mem2write_req_*         per-channel write request (val/rdy/addr/data)
//   mem2write_resp_val      per-channel one-cycle write-complete pulse
//   init_*                  backdoor preload (we/sel/addr/data), sel=1 -> data
// -----------------------------------------------------------------------------
module global_mem_model #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 16,
    parameter int NUM_CHAN       = 4,
    parameter int LATENCY        = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               mem2fetch_req_val,
    output logic                               mem2fetch_req_rdy,
    input  logic [MEM_ADDR_WIDTH-1:0]          mem2fetch_req_addr,
    output logic                               mem2fetch_resp_val,
    input  logic                               mem2fetch_resp_rdy,
    output logic [MEM_DATA_WIDTH-1:0]          mem2fetch_resp_inst,
    input  logic [NUM_CHAN-1:0]                mem2read_req_addr_val,
    output logic [NUM_CHAN-1:0]                mem2read_req_rdy,
    input  logic [NUM_CHAN*MEM_ADDR_WIDTH-1:0] mem2read_req_addr,
    output logic [NUM_CHAN-1:0]                mem2read_resp_data_val,
    input  logic [NUM_CHAN-1:0]                mem2read_resp_rdy,
    output logic [NUM_CHAN*MEM_DATA_WIDTH-1:0] mem2read_resp_data,
    input  logic [NUM_CHAN-1:0]                mem2write_req_val,
    output logic [NUM_CHAN-1:0]                mem2write_req_rdy,
    input  logic [NUM_CHAN*MEM_ADDR_WIDTH-1:0] mem2write_req_addr,
    input  logic [NUM_CHAN*MEM_DATA_WIDTH-1:0] mem2write_req_data,
    output logic [NUM_CHAN-1:0]                mem2write_resp_val,
    input  logic                               init_we,
    input  logic                               init_sel,
    input  logic [MEM_ADDR_WIDTH-1:0]          init_addr,
    input  logic [MEM_DATA_WIDTH-1:0]          init_data
);

    localparam int         AW       = MEM_ADDR_WIDTH;
    localparam int         DW       = MEM_DATA_WIDTH;
    localparam int         DEPTH    = 1 << AW;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [DW-1:0] inst_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    // Registered copy of reset: keeps every req_rdy low for the whole time
    // reset is held without a combinational path from the reset pin.
    logic rst_q;
    always_ff @(posedge clk) begin
        rst_q <= reset;
    end

    // ---------------------------------------------------------------- fetch
    state_t        f_state_q, f_state_d;
    logic [3:0]    f_cnt_q;
    logic [AW-1:0] f_addr_q;
    logic [DW-1:0] f_inst_q;
    logic          f_accept;

    always_comb begin
        f_state_d = f_state_q;
        f_accept  = 1'b0;
        case (f_state_q)
            S_IDLE: if (!rst_q && mem2fetch_req_val) begin
                f_accept  = 1'b1;
                f_state_d = S_BUSY;
            end
            S_BUSY: if (f_cnt_q == 4'd0) f_state_d = S_RESP;
            S_RESP: if (mem2fetch_resp_rdy) f_state_d = S_IDLE;
            default: f_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_state_q <= S_IDLE;
            f_cnt_q   <= 4'd0;
            f_addr_q  <= '0;
            f_inst_q  <= '0;
        end else begin
            f_state_q <= f_state_d;
            if (f_accept) begin
                f_addr_q <= mem2fetch_req_addr;
                f_cnt_q  <= CNT_LOAD;
            end else if (f_state_q == S_BUSY) begin
                if (f_cnt_q != 4'd0) f_cnt_q <= f_cnt_q - 4'd1;
                else                 f_inst_q <= inst_mem[f_addr_q];
            end
        end
    end

    assign mem2fetch_req_rdy   = (f_state_q == S_IDLE) && !rst_q;
    assign mem2fetch_resp_val  = (f_state_q == S_RESP);
    assign mem2fetch_resp_inst = f_inst_q;

    always_ff @(posedge clk) begin
        if (init_we && !init_sel) inst_mem[init_addr] <= init_data;
    end

    // --------------------------------------------------------- data channels
    logic [NUM_CHAN-1:0] wr_commit;
    logic [AW-1:0]       commit_addr [NUM_CHAN];
    logic [DW-1:0]       commit_data [NUM_CHAN];

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        state_t        state_q, state_d;
        logic [3:0]    cnt_q;
        logic          is_wr_q;
        logic [AW-1:0] addr_q;
        logic [DW-1:0] wdata_q;
        logic [DW-1:0] rdata_q;
        logic          acc_rd, acc_wr;

        // Read wins over a write presented in the same cycle; the write stays
        // unaccepted and must be re-presented by the requester.
        always_comb begin
            state_d = state_q;
            acc_rd  = 1'b0;
            acc_wr  = 1'b0;
            case (state_q)
                S_IDLE: if (!rst_q) begin
                    if (mem2read_req_addr_val[c]) begin
                        acc_rd  = 1'b1;
                        state_d = S_BUSY;
                    end else if (mem2write_req_val[c]) begin
                        acc_wr  = 1'b1;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: if (cnt_q == 4'd0) state_d = S_RESP;
                // A write spends exactly one cycle in RESP to emit its pulse;
                // a read waits there for the response handshake.
                S_RESP: if (is_wr_q || mem2read_resp_rdy[c]) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= S_IDLE;
                cnt_q   <= 4'd0;
                is_wr_q <= 1'b0;
                addr_q  <= '0;
                wdata_q <= '0;
                rdata_q <= '0;
            end else begin
                state_q <= state_d;
                if (acc_rd || acc_wr) begin
                    addr_q  <= acc_wr ? mem2write_req_addr[c*AW +: AW]
                                      : mem2read_req_addr[c*AW +: AW];
                    wdata_q <= mem2write_req_data[c*DW +: DW];
                    is_wr_q <= acc_wr;
                    cnt_q   <= CNT_LOAD;
                end else if (state_q == S_BUSY) begin
                    if (cnt_q != 4'd0)  cnt_q   <= cnt_q - 4'd1;
                    else if (!is_wr_q)  rdata_q <= data_mem[addr_q];
                end
            end
        end

        // Reset on the commit edge abandons the write.
        assign wr_commit[c]   = (state_q == S_BUSY) && (cnt_q == 4'd0) && is_wr_q && !reset;
        assign commit_addr[c] = addr_q;
        assign commit_data[c] = wdata_q;

        assign mem2read_req_rdy[c]             = (state_q == S_IDLE) && !rst_q;
        assign mem2write_req_rdy[c]            = (state_q == S_IDLE) && !rst_q;
        assign mem2read_resp_data_val[c]       = (state_q == S_RESP) && !is_wr_q;
        assign mem2write_resp_val[c]           = (state_q == S_RESP) && is_wr_q;
        assign mem2read_resp_data[c*DW +: DW]  = rdata_q;
    end

    // Later assignments win: backdoor first, then channels from highest to
    // lowest index so the lowest-indexed channel owns a contested word.
    always_ff @(posedge clk) begin
        if (init_we && init_sel) data_mem[init_addr] <= init_data;
        for (int c = NUM_CHAN - 1; c >= 0; c--) begin
            if (wr_commit[c]) data_mem[commit_addr[c]] <= commit_data[c];
        end
    end

endmodule

// File: tb/tb_global_mem_model.sv
// -----------------------------------------------------------------------------
// tb_global_mem_model
//
// Three instances share one clock: instance 0 (LATENCY=2) gets directed,
// cycle-exact steps; instances 1 (LATENCY=1) and 2 (LATENCY=15) get a random
// concurrent sweep on all data channels plus fetch. Expected read data comes
// from array models: a read accepted on edge A returns memory as left by all
// writes accepted on edges before A (equal latency for reads and writes), with
// same-edge writes applied lowest channel last.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_global_mem_model;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int NI = 3;

  logic clk;
  logic reset;

  logic          f_val [NI];
  logic          f_rdy [NI];
  logic [AW-1:0] f_addr [NI];
  logic          f_resp_val [NI];
  logic          f_resp_rdy [NI];
  logic [DW-1:0] f_inst [NI];

  logic [NC-1:0]    rd_val [NI];
  logic [NC-1:0]    rd_rdy [NI];
  logic [NC*AW-1:0] rd_addr [NI];
  logic [NC-1:0]    rresp_val [NI];
  logic [NC-1:0]    rresp_rdy [NI];
  logic [NC*DW-1:0] rresp_data [NI];

  logic [NC-1:0]    wr_val [NI];
  logic [NC-1:0]    wr_rdy [NI];
  logic [NC*AW-1:0] wr_addr [NI];
  logic [NC*DW-1:0] wr_data [NI];
  logic [NC-1:0]    wresp [NI];

  logic          init_we [NI];
  logic          init_sel [NI];
  logic [AW-1:0] init_addr [NI];
  logic [DW-1:0] init_data [NI];

  // ------------------------------------------------------------ clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    global_mem_model #(
      .MEM_ADDR_WIDTH (AW),
      .MEM_DATA_WIDTH (DW),
      .NUM_CHAN       (NC),
      .LATENCY        (g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk                    (clk),
      .reset                  (reset),
      .mem2fetch_req_val      (f_val[g]),
      .mem2fetch_req_rdy      (f_rdy[g]),
      .mem2fetch_req_addr     (f_addr[g]),
      .mem2fetch_resp_val     (f_resp_val[g]),
      .mem2fetch_resp_rdy     (f_resp_rdy[g]),
      .mem2fetch_resp_inst    (f_inst[g]),
      .mem2read_req_addr_val  (rd_val[g]),
      .mem2read_req_rdy       (rd_rdy[g]),
      .mem2read_req_addr      (rd_addr[g]),
      .mem2read_resp_data_val (rresp_val[g]),
      .mem2read_resp_rdy      (rresp_rdy[g]),
      .mem2read_resp_data     (rresp_data[g]),
      .mem2write_req_val      (wr_val[g]),
      .mem2write_req_rdy      (wr_rdy[g]),
      .mem2write_req_addr     (wr_addr[g]),
      .mem2write_req_data     (wr_data[g]),
      .mem2write_resp_val     (wresp[g]),
      .init_we                (init_we[g]),
      .init_sel               (init_sel[g]),
      .init_addr              (init_addr[g]),
      .init_data              (init_data[g])
    );
  end

  // ------------------------------------------------------------- scoreboard
  logic [DW-1:0] dmem_m [NI][256];
  logic [DW-1:0] imem_m [NI][256];
  logic [DW-1:0] exp_q [10][$];
  int            wr_pend [10];
  int            n_checks;
  int            n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input int k, input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    init_we[k]   = 1'b1;
    init_sel[k]  = sel;
    init_addr[k] = a;
    init_data[k] = d;
    if (sel) dmem_m[k][a] = d;
    else     imem_m[k][a] = d;
    tick();
    init_we[k] = 1'b0;
  endtask

  // Issue a read on instance 0 with resp_rdy high and check the returned word.
  task automatic do_read(input int c, input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    bit seen;
    seen = 1'b0;
    rd_val[0][c] = 1'b1;
    rd_addr[0][c*AW +: AW] = a;
    rresp_rdy[0][c] = 1'b1;
    tick();
    rd_val[0][c] = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      if (rresp_val[0][c]) seen = 1'b1;
      else tick();
    end
    check({tag, "_seen"}, seen, 1);
    if (seen) check(tag, rresp_data[0][c*DW +: DW], exp);
    tick();
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    f_val[0] = 1'b1;
    f_addr[0] = a;
    f_resp_rdy[0] = 1'b1;
    tick();
    f_val[0] = 1'b0;
    tick();
    check({tag, "_val_e1"}, f_resp_val[0], 0);
    tick();
    check({tag, "_val_e2"}, f_resp_val[0], 1);
    check({tag, "_inst"}, f_inst[0], exp);
    tick();
    check({tag, "_val_after"}, f_resp_val[0], 0);
  endtask

  // --------------------------------------------------------------- stimulus
  int            q;
  bit            stop;
  logic [AW-1:0] a;
  logic [DW-1:0] e;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    for (int k = 0; k < NI; k++) begin
      f_val[k] = 1'b0; f_addr[k] = '0; f_resp_rdy[k] = 1'b0;
      rd_val[k] = '0; rd_addr[k] = '0; rresp_rdy[k] = '0;
      wr_val[k] = '0; wr_addr[k] = '0; wr_data[k] = '0;
      init_we[k] = 1'b0; init_sel[k] = 1'b0; init_addr[k] = '0; init_data[k] = '0;
    end
    for (int i = 0; i < 10; i++) wr_pend[i] = 0;

    // Reset state
    repeat (3) tick();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_f_rdy_%0d", k), f_rdy[k], 0);
      check($sformatf("rst_f_val_%0d", k), f_resp_val[k], 0);
      check($sformatf("rst_f_inst_%0d", k), f_inst[k], 0);
      check($sformatf("rst_rd_rdy_%0d", k), rd_rdy[k], 0);
      check($sformatf("rst_wr_rdy_%0d", k), wr_rdy[k], 0);
      check($sformatf("rst_rresp_%0d", k), rresp_val[k], 0);
      check($sformatf("rst_rdata_%0d", k), rresp_data[k][31:0], 0);
      check($sformatf("rst_wresp_%0d", k), wresp[k], 0);
    end
    reset = 1'b0;
    tick();
    check("rdy_after_rst_rd", rd_rdy[0], 4'hF);
    check("rdy_after_rst_wr", wr_rdy[0], 4'hF);
    check("rdy_after_rst_f", f_rdy[0], 1);

    // Read at LATENCY=2 on channel 2
    bd_write(0, 1'b1, 8'h10, 16'hBEEF);
    rresp_rdy[0] = 4'hF;
    rd_val[0][2] = 1'b1;
    rd_addr[0][2*AW +: AW] = 8'h10;
    check("t1_rdy_before", rd_rdy[0][2], 1);
    tick();
    rd_val[0][2] = 1'b0;
    check("t1_rdy_busy", rd_rdy[0][2], 0);
    check("t1_val_e0", rresp_val[0][2], 0);
    tick();
    check("t1_val_e1", rresp_val[0][2], 0);
    tick();
    check("t1_val_e2", rresp_val[0][2], 1);
    check("t1_data", rresp_data[0][2*DW +: DW], 16'hBEEF);
    tick();
    check("t1_val_e3", rresp_val[0][2], 0);
    check("t1_rdy_e3", rd_rdy[0][2], 1);
    check("t1_data_hold", rresp_data[0][2*DW +: DW], 16'hBEEF);

    // Backpressure for 4 cycles
    rresp_rdy[0][2] = 1'b0;
    rd_val[0][2] = 1'b1;
    tick();
    rd_val[0][2] = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_val_%0d", i), rresp_val[0][2], 1);
      check($sformatf("t2_data_%0d", i), rresp_data[0][2*DW +: DW], 16'hBEEF);
      check($sformatf("t2_rdy_%0d", i), rd_rdy[0][2], 0);
      if (i < 3) tick();
    end
    rresp_rdy[0][2] = 1'b1;
    tick();
    check("t2_val_done", rresp_val[0][2], 0);
    check("t2_rdy_done", rd_rdy[0][2], 1);

    // Write on channel 0, then read on channel 3
    wr_val[0][0] = 1'b1;
    wr_addr[0][0 +: AW] = 8'h20;
    wr_data[0][0 +: DW] = 16'h1234;
    tick();
    wr_val[0][0] = 1'b0;
    check("t3_wresp_e0", wresp[0][0], 0);
    tick();
    check("t3_wresp_e1", wresp[0][0], 0);
    tick();
    check("t3_wresp_e2", wresp[0][0], 1);
    check("t3_wrdy_e2", wr_rdy[0][0], 0);
    tick();
    check("t3_wresp_e3", wresp[0][0], 0);
    check("t3_wrdy_e3", wr_rdy[0][0], 1);
    do_read(3, 8'h20, 16'h1234, "t3_rd");

    // Same-edge writes to one address: channel 1 wins over channel 2
    wr_val[0][1] = 1'b1;
    wr_val[0][2] = 1'b1;
    wr_addr[0][1*AW +: AW] = 8'h30;
    wr_addr[0][2*AW +: AW] = 8'h30;
    wr_data[0][1*DW +: DW] = 16'hAAAA;
    wr_data[0][2*DW +: DW] = 16'h5555;
    tick();
    wr_val[0] = '0;
    repeat (3) tick();
    do_read(0, 8'h30, 16'hAAAA, "t4_prio");

    // Read and write valid together on channel 1: only the read is taken
    rd_val[0][1] = 1'b1;
    rd_addr[0][1*AW +: AW] = 8'h10;
    wr_val[0][1] = 1'b1;
    wr_addr[0][1*AW +: AW] = 8'h10;
    wr_data[0][1*DW +: DW] = 16'hDEAD;
    tick();
    rd_val[0][1] = 1'b0;
    wr_val[0][1] = 1'b0;
    check("t5_wrdy_busy", wr_rdy[0][1], 0);
    tick();
    check("t5_wresp_e1", wresp[0][1], 0);
    tick();
    check("t5_rval", rresp_val[0][1], 1);
    check("t5_rdata", rresp_data[0][1*DW +: DW], 16'hBEEF);
    check("t5_wresp_e2", wresp[0][1], 0);
    tick();
    check("t5_wresp_e3", wresp[0][1], 0);
    do_read(1, 8'h10, 16'hBEEF, "t5_nowrite");

    // Fetch, then reset while a fetch and a write are in BUSY
    bd_write(0, 1'b0, 8'h00, 16'h7001);
    bd_write(0, 1'b1, 8'h40, 16'h0001);
    do_fetch(8'h00, 16'h7001, "t6_fetch");
    f_val[0] = 1'b1;
    f_addr[0] = 8'h00;
    wr_val[0][0] = 1'b1;
    wr_addr[0][0 +: AW] = 8'h40;
    wr_data[0][0 +: DW] = 16'h9999;
    tick();
    f_val[0] = 1'b0;
    wr_val[0][0] = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("t6_rst_fval", f_resp_val[0], 0);
    check("t6_rst_frdy", f_rdy[0], 0);
    check("t6_rst_rdata2", rresp_data[0][2*DW +: DW], 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6_no_fresp_%0d", i), f_resp_val[0], 0);
      check($sformatf("t6_no_wresp_%0d", i), wresp[0][0], 0);
    end
    do_fetch(8'h00, 16'h7001, "t6_refetch");
    do_read(0, 8'h40, 16'h0001, "t6_wr_abandoned");

    // Preload instances 1 and 2 for the sweep
    for (int ad = 0; ad < 16; ad++) begin
      for (int sel = 0; sel < 2; sel++) begin
        for (int k = 1; k < NI; k++) begin
          init_we[k]   = 1'b1;
          init_sel[k]  = sel[0];
          init_addr[k] = AW'(ad);
          init_data[k] = DW'($urandom);
          if (sel == 1) dmem_m[k][ad] = init_data[k];
          else          imem_m[k][ad] = init_data[k];
        end
        tick();
      end
    end
    for (int k = 1; k < NI; k++) init_we[k] = 1'b0;

    // Random concurrent sweep at LATENCY=1 and LATENCY=15, then drain
    for (int cyc = 0; cyc < 440; cyc++) begin
      stop = (cyc >= 400);
      for (int k = 1; k < NI; k++) begin
        for (int c = 0; c < NC; c++) begin
          q = (k - 1) * 5 + c;
          if (wresp[k][c]) begin
            check($sformatf("sw_wresp_k%0d_c%0d", k, c), wr_pend[q] > 0, 1);
            if (wr_pend[q] > 0) wr_pend[q]--;
          end
          rresp_rdy[k][c] = stop ? 1'b1 : 1'($urandom_range(0, 1));
          if (rresp_val[k][c] && rresp_rdy[k][c]) begin
            check($sformatf("sw_rresp_expected_k%0d_c%0d", k, c), exp_q[q].size() > 0, 1);
            if (exp_q[q].size() > 0) begin
              e = exp_q[q].pop_front();
              check($sformatf("sw_rdata_k%0d_c%0d", k, c), rresp_data[k][c*DW +: DW], e);
            end
          end
          rd_val[k][c] = !stop && ($urandom_range(0, 2) == 0);
          wr_val[k][c] = !stop && ($urandom_range(0, 2) == 0);
          rd_addr[k][c*AW +: AW] = AW'($urandom_range(0, 15));
          wr_addr[k][c*AW +: AW] = AW'($urandom_range(0, 15));
          wr_data[k][c*DW +: DW] = DW'($urandom);
        end
        // Reads accepted this edge see memory before this edge's writes.
        for (int c = 0; c < NC; c++) begin
          if (rd_rdy[k][c] && rd_val[k][c]) begin
            a = rd_addr[k][c*AW +: AW];
            exp_q[(k - 1) * 5 + c].push_back(dmem_m[k][a]);
          end
        end
        for (int c = NC - 1; c >= 0; c--) begin
          if (wr_rdy[k][c] && wr_val[k][c] && !rd_val[k][c]) begin
            a = wr_addr[k][c*AW +: AW];
            dmem_m[k][a] = wr_data[k][c*DW +: DW];
            wr_pend[(k - 1) * 5 + c]++;
          end
        end
        q = (k - 1) * 5 + 4;
        f_resp_rdy[k] = stop ? 1'b1 : 1'($urandom_range(0, 1));
        if (f_resp_val[k] && f_resp_rdy[k]) begin
          check($sformatf("sw_fresp_expected_k%0d", k), exp_q[q].size() > 0, 1);
          if (exp_q[q].size() > 0) begin
            e = exp_q[q].pop_front();
            check($sformatf("sw_finst_k%0d", k), f_inst[k], e);
          end
        end
        f_val[k] = !stop && ($urandom_range(0, 1) == 0);
        f_addr[k] = AW'($urandom_range(0, 15));
        if (f_rdy[k] && f_val[k]) exp_q[q].push_back(imem_m[k][f_addr[k]]);
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4 || i % 5 < NC) begin
        check($sformatf("sw_drain_rd_q%0d", i), exp_q[i].size(), 0);
        check($sformatf("sw_drain_wr_q%0d", i), wr_pend[i], 0);
      end
    end

    // ------------------------------------------------------------- report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
